// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: control word, funct3 encodings, memory mask and LSU state.
package rv32i_types;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef logic [3:0] rv32i_mem_wmask;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } lsu_state_t;

  typedef struct packed {
    logic load_regfile;
    logic data_read;
    logic data_write;
  } rv32i_control_word;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store mask/data steering, load shift and extension,
// and natural-alignment check for halfword and word accesses.
module lsu_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] load_data,
  output logic [3:0]  mbe,
  output logic [31:0] wdata,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [31:0] shifted;

  assign shifted = load_data >> {offset, 3'b000};

  always_comb begin
    mbe   = 4'h0;
    wdata = store_data;
    case (funct3)
      sb: begin
        mbe   = 4'b0001 << offset;
        wdata = {4{store_data[7:0]}};
      end
      sh: begin
        mbe   = 4'b0011 << offset;
        wdata = {2{store_data[15:0]}};
      end
      sw:      mbe = 4'hF;
      default: mbe = 4'h0;
    endcase
  end

  always_comb begin
    case (funct3)
      lb:      rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      lh:      rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      lbu:     rdata_ext = {24'h0, shifted[7:0]};
      lhu:     rdata_ext = {16'h0, shifted[15:0]};
      default: rdata_ext = load_data;
    endcase
  end

  // lw and sw share encoding 3'b010, lh and sh share 3'b001.
  always_comb begin
    case (funct3)
      lw:       misaligned = |offset;
      lh, lhu:  misaligned = offset[0];
      default:  misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// MEM-stage load/store unit: issues one cache request per aligned memory op, stalls
// upstream until data_resp, and registers the extended load result for writeback.
module data_mem_unit
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  rv32i_control_word ex_ctrl,
  input  logic [2:0]        ex_funct3,
  input  logic [31:0]       ex_addr,
  input  logic [31:0]       ex_rs2,
  input  logic [4:0]        ex_rd,
  output logic              stall,
  output logic              data_read,
  output logic              data_write,
  output logic [31:0]       data_addr,
  output logic [31:0]       data_wdata,
  output logic [3:0]        data_mbe,
  input  logic [31:0]       data_rdata,
  input  logic              data_resp,
  output logic              wb_valid,
  output logic              wb_load_regfile,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              wb_misaligned
);

  lsu_state_t state, next_state;

  logic        mem_op, ex_read, ex_write, accept, done;
  logic [3:0]  st_mbe, ld_mbe;
  logic [31:0] st_wdata, st_ext, ld_wdata, ld_ext;
  logic        st_mis, ld_mis;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_offset;
  logic [4:0]  lat_rd;
  logic        lat_load_regfile;
  logic        unused_bits;

  assign ex_read  = ex_ctrl.data_read;
  assign ex_write = ex_ctrl.data_write & ~ex_ctrl.data_read;
  assign mem_op   = ex_valid & (ex_ctrl.data_read | ex_ctrl.data_write);

  lsu_align u_store_align (
    .funct3     (ex_funct3),
    .offset     (ex_addr[1:0]),
    .store_data (ex_rs2),
    .load_data  (data_rdata),
    .mbe        (st_mbe),
    .wdata      (st_wdata),
    .rdata_ext  (st_ext),
    .misaligned (st_mis)
  );

  lsu_align u_load_align (
    .funct3     (lat_funct3),
    .offset     (lat_offset),
    .store_data (32'h0),
    .load_data  (data_rdata),
    .mbe        (ld_mbe),
    .wdata      (ld_wdata),
    .rdata_ext  (ld_ext),
    .misaligned (ld_mis)
  );

  assign unused_bits = ^{st_ext, ld_mbe, ld_wdata, ld_mis};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (mem_op && !st_mis) next_state = ACCESS;
      ACCESS:  if (data_resp)         next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    accept = 1'b0;
    done   = 1'b0;
    stall  = 1'b0;
    case (state)
      IDLE: begin
        accept = mem_op & ~st_mis;
        stall  = accept;
      end
      ACCESS: begin
        done  = data_resp;
        stall = ~data_resp;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_read        <= 1'b0;
      data_write       <= 1'b0;
      data_addr        <= 32'h0;
      data_wdata       <= 32'h0;
      data_mbe         <= 4'h0;
      wb_valid         <= 1'b0;
      wb_load_regfile  <= 1'b0;
      wb_rd            <= 5'h0;
      wb_data          <= 32'h0;
      wb_misaligned    <= 1'b0;
      lat_funct3       <= 3'h0;
      lat_offset       <= 2'h0;
      lat_rd           <= 5'h0;
      lat_load_regfile <= 1'b0;
    end else begin
      wb_misaligned <= 1'b0;
      if (accept) begin
        data_read        <= ex_read;
        data_write       <= ex_write;
        data_addr        <= {ex_addr[31:2], 2'b00};
        data_wdata       <= st_wdata;
        data_mbe         <= ex_write ? st_mbe : 4'h0;
        lat_funct3       <= ex_funct3;
        lat_offset       <= ex_addr[1:0];
        lat_rd           <= ex_rd;
        lat_load_regfile <= ex_ctrl.load_regfile;
        wb_valid         <= 1'b0;
      end else if (done) begin
        data_read  <= 1'b0;
        data_write <= 1'b0;
        data_mbe   <= 4'h0;
        wb_valid   <= 1'b1;
        wb_rd      <= lat_rd;
        if (data_read) begin
          wb_load_regfile <= lat_load_regfile;
          wb_data         <= ld_ext;
        end else begin
          wb_load_regfile <= 1'b0;
        end
      end else if (state == IDLE) begin
        // A memory op reaching here was rejected for misalignment.
        wb_valid <= ex_valid;
        wb_rd    <= ex_rd;
        wb_data  <= ex_addr;
        if (mem_op) begin
          wb_load_regfile <= 1'b0;
          wb_misaligned   <= 1'b1;
        end else begin
          wb_load_regfile <= ex_ctrl.load_regfile;
        end
      end else begin
        wb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Randomized scoreboard bench for data_mem_unit: a driver issues ops and queues expected
// cache requests and writeback results; a cache responder and a WB monitor compare them.
module tb_data_mem_unit;
  import rv32i_types::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid;
  rv32i_control_word ex_ctrl;
  logic [2:0]        ex_funct3;
  logic [31:0]       ex_addr, ex_rs2;
  logic [4:0]        ex_rd;
  logic              stall, data_read, data_write;
  logic [31:0]       data_addr, data_wdata, data_rdata;
  logic [3:0]        data_mbe;
  logic              data_resp;
  logic              wb_valid, wb_load_regfile, wb_misaligned;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_data;

  always #5 clk = ~clk;

  data_mem_unit dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_funct3(ex_funct3),
    .ex_addr(ex_addr), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .stall(stall),
    .data_read(data_read), .data_write(data_write), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_mbe(data_mbe), .data_rdata(data_rdata),
    .data_resp(data_resp), .wb_valid(wb_valid), .wb_load_regfile(wb_load_regfile),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_misaligned(wb_misaligned)
  );

  typedef struct {
    bit        valid, rdb, wrb, lrf;
    bit [2:0]  f3;
    bit [31:0] addr, rs2, rdata;
    bit [4:0]  rd;
    int        delay;
  } op_t;

  typedef struct {
    bit        rdb, wrb;
    bit [31:0] addr, wdata, rdata;
    bit [3:0]  mbe;
    int        delay;
  } req_t;

  typedef struct {
    bit        lrf, mis, chk;
    bit [4:0]  rd;
    bit [31:0] data;
  } wb_t;

  req_t reqq[$];
  wb_t  wbq[$];
  int   errors = 0;
  int   checks = 0;
  bit   spur_en = 1'b0;
  bit   resp_en = 1'b1;
  bit   late_pulse = 1'b0;
  bit   late_done = 1'b0;
  bit [2:0] load_f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit mis_model(bit [2:0] f3, bit [1:0] k);
    if (f3 == 3'd2) return k != 2'd0;
    if (f3 == 3'd1 || f3 == 3'd5) return k[0];
    return 1'b0;
  endfunction

  function automatic bit [31:0] load_model(bit [2:0] f3, bit [1:0] k, bit [31:0] w);
    int unsigned b, h;
    int s;
    b = (w >> (8 * k)) & 32'hFF;
    h = (w >> (8 * k)) & 32'hFFFF;
    case (f3)
      3'd0:    s = (b >= 128)   ? int'(b) - 256   : int'(b);
      3'd1:    s = (h >= 32768) ? int'(h) - 65536 : int'(h);
      3'd4:    s = int'(b);
      3'd5:    s = int'(h);
      default: s = int'(w);
    endcase
    return s;
  endfunction

  // Byte i is written when it falls inside [k, k+size); data repeats the low bytes of rs2.
  function automatic void store_model(bit [2:0] f3, bit [1:0] k, bit [31:0] rs2,
                                      output bit [3:0] m, output bit [31:0] wd);
    int size;
    size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    for (int i = 0; i < 4; i++) begin
      m[i] = (i >= int'(k)) && (i < int'(k) + size);
      wd[8*i +: 8] = rs2[8*(i % size) +: 8];
    end
  endfunction

  function automatic op_t mk(bit v, bit r, bit w, bit l, bit [2:0] f3, bit [31:0] a,
                             bit [31:0] s, bit [31:0] rdat, bit [4:0] rd, int d);
    op_t o;
    o.valid = v; o.rdb = r; o.wrb = w; o.lrf = l; o.f3 = f3; o.addr = a;
    o.rs2 = s; o.rdata = rdat; o.rd = rd; o.delay = d;
    return o;
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    int kind;
    kind = $urandom_range(0, 5);
    o = mk(1'b1, 1'b0, 1'b0, 1'($urandom), 3'd0, $urandom, $urandom, $urandom,
           5'($urandom), $urandom_range(0, 3));
    case (kind)
      1, 2: begin o.rdb = 1'b1; o.f3 = load_f3s[$urandom_range(0, 4)]; end
      3: begin
        o.wrb = 1'b1;
        o.f3  = 3'($urandom_range(0, 2));
        if (o.f3 == 3'd2) o.addr[1:0] = 2'b00;
      end
      4: begin o.valid = 1'b0; o.rdb = 1'($urandom); o.wrb = 1'($urandom); end
      5: begin o.rdb = 1'b1; o.wrb = 1'b1; o.f3 = load_f3s[$urandom_range(0, 4)]; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic run_op(op_t o);
    bit   is_mem, mis, rdw, wrw;
    int   n;
    req_t q;
    wb_t  e;
    @(posedge clk); #1;
    ex_valid = o.valid;
    ex_ctrl.load_regfile = o.lrf;
    ex_ctrl.data_read    = o.rdb;
    ex_ctrl.data_write   = o.wrb;
    ex_funct3 = o.f3; ex_addr = o.addr; ex_rs2 = o.rs2; ex_rd = o.rd;
    is_mem = o.valid && (o.rdb || o.wrb);
    rdw = o.rdb;
    wrw = o.wrb && !o.rdb;
    mis = is_mem && mis_model(o.f3, o.addr[1:0]);
    if (o.valid) begin
      e.rd = o.rd; e.mis = 1'b0; e.chk = 1'b1; e.lrf = o.lrf; e.data = o.addr;
      if (mis) begin
        e.lrf = 1'b0; e.mis = 1'b1; e.chk = 1'b0;
      end else if (is_mem && rdw) begin
        e.data = load_model(o.f3, o.addr[1:0], o.rdata);
      end else if (is_mem) begin
        e.lrf = 1'b0; e.chk = 1'b0;
      end
      wbq.push_back(e);
    end
    if (is_mem && !mis) begin
      q.rdb = rdw; q.wrb = wrw; q.addr = {o.addr[31:2], 2'b00};
      q.rdata = o.rdata; q.delay = o.delay; q.mbe = 4'h0; q.wdata = 32'h0;
      if (wrw) store_model(o.f3, o.addr[1:0], o.rs2, q.mbe, q.wdata);
      reqq.push_back(q);
    end
    n = 0;
    forever begin
      @(negedge clk); #1;
      if (n == 0) check("stall_first", 32'(stall), 32'(is_mem && !mis));
      if (!stall) break;
      n++;
      if (n > 100) begin
        check("stall_timeout", 32'(stall), 32'd0);
        break;
      end
    end
    if (is_mem && !mis && !spur_en) check("stall_cycles", n, o.delay + 1);
  endtask

  // Cache responder: checks each request against the queue, holds, then answers.
  initial begin
    req_t r;
    data_resp  = 1'b0;
    data_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
      end else if (late_pulse && !late_done) begin
        data_resp = 1'b1;
        @(negedge clk);
        data_resp = 1'b0;
        late_done = 1'b1;
      end else if (resp_en && (data_read || data_write)) begin
        if (reqq.size() == 0) begin
          check("req_unexpected", 32'(data_read), 32'd0);
          r.delay = 0; r.rdata = 32'h0; r.rdb = data_read; r.wrb = data_write;
          r.addr = data_addr;
        end else begin
          r = reqq.pop_front();
          check("req_read", 32'(data_read), 32'(r.rdb));
          check("req_write", 32'(data_write), 32'(r.wrb));
          check("req_addr", data_addr, r.addr);
          check("req_mbe", 32'(data_mbe), 32'(r.mbe));
          if (r.wrb) check("req_wdata", data_wdata, r.wdata);
        end
        repeat (r.delay) begin
          @(negedge clk);
          check("req_held", {30'd0, data_read, data_write}, {30'd0, r.rdb, r.wrb});
          check("req_addr_held", data_addr, r.addr);
        end
        data_rdata = r.rdata;
        data_resp  = 1'b1;
        @(negedge clk);
        data_resp  = 1'b0;
        data_rdata = $urandom;
      end else if (spur_en && resp_en && $urandom_range(0, 7) == 0) begin
        data_resp = 1'b1;
        @(negedge clk);
        data_resp = 1'b0;
      end
    end
  end

  // Writeback monitor.
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (!rst && wb_valid === 1'b1) begin
        if (wbq.size() == 0) begin
          check("wb_unexpected", 32'(wb_valid), 32'd0);
        end else begin
          e = wbq.pop_front();
          check("wb_load_regfile", 32'(wb_load_regfile), 32'(e.lrf));
          check("wb_misaligned", 32'(wb_misaligned), 32'(e.mis));
          if (e.chk) begin
            check("wb_data", wb_data, e.data);
            check("wb_rd", 32'(wb_rd), 32'(e.rd));
          end
        end
      end else if (!rst && wb_misaligned === 1'b1) begin
        check("misaligned_without_valid", 32'(wb_misaligned), 32'd0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t dir [$];
    rst = 1'b1; ex_valid = 1'b0; ex_ctrl = '0; ex_funct3 = 3'd0;
    ex_addr = 32'h0; ex_rs2 = 32'h0; ex_rd = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req", {30'd0, data_read, data_write}, 32'd0);
    check("rst_mbe", 32'(data_mbe), 32'd0);
    check("rst_addr", data_addr, 32'd0);
    check("rst_wdata", data_wdata, 32'd0);
    check("rst_wb_flags", {29'd0, wb_valid, wb_load_regfile, wb_misaligned}, 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    dir.push_back(mk(1, 0, 0, 1, 3'd0, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 0));
    dir.push_back(mk(1, 1, 0, 1, 3'd0, 32'h0000_1003, 32'h0, 32'h80FF_FFFF, 5'd6, 3));
    dir.push_back(mk(1, 1, 0, 1, 3'd4, 32'h0000_1003, 32'h0, 32'h80FF_FFFF, 5'd7, 3));
    dir.push_back(mk(1, 0, 1, 1, 3'd1, 32'h0000_2002, 32'hAAAA_BEEF, 32'h0, 5'd8, 2));
    dir.push_back(mk(1, 1, 0, 1, 3'd2, 32'h0000_3001, 32'h0, 32'h0, 5'd9, 0));
    dir.push_back(mk(1, 1, 0, 1, 3'd2, 32'h0000_4000, 32'h0, 32'h1357_9BDF, 5'd10, 0));
    dir.push_back(mk(1, 0, 1, 0, 3'd2, 32'h0000_4004, 32'hCAFE_F00D, 32'h0, 5'd11, 0));
    dir.push_back(mk(1, 1, 1, 1, 3'd5, 32'h0000_500A, 32'h1111_2222, 32'h8765_4321, 5'd12, 1));
    foreach (dir[i]) run_op(dir[i]);

    spur_en = 1'b1;
    for (int i = 0; i < 300; i++) run_op(rnd_op());
    @(posedge clk); #1 ex_valid = 1'b0;
    for (int i = 0; i < 50 && wbq.size() != 0; i++) @(negedge clk);
    check("drain_wb", wbq.size(), 0);
    check("drain_req", reqq.size(), 0);

    // Reset while a load is outstanding; a late response must be dropped.
    spur_en = 1'b0;
    resp_en = 1'b0;
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_ctrl = '0; ex_ctrl.data_read = 1'b1; ex_ctrl.load_regfile = 1'b1;
    ex_funct3 = 3'd2; ex_addr = 32'h0000_0040; ex_rd = 5'd3;
    @(negedge clk); #1 check("midrst_accept_stall", 32'(stall), 32'd1);
    @(posedge clk); #1 ex_valid = 1'b0; ex_ctrl = '0;
    @(negedge clk); check("midrst_req_before", 32'(data_read), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    check("midrst_req_after", {30'd0, data_read, data_write}, 32'd0);
    check("midrst_stall_after", 32'(stall), 32'd0);
    late_pulse = 1'b1;
    for (int i = 0; i < 20 && !late_done; i++) @(negedge clk);
    check("late_resp_sent", 32'(late_done), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("midrst_wb_valid", 32'(wb_valid), 32'd0);
    end
    check("final_wbq", wbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
